// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding, address
// regions, default timeout and the region-to-chip-select decode.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [1:0] REG_IO    = 2'd0;
  localparam logic [1:0] REG_RAM   = 2'd1;
  localparam logic [1:0] REG_FLASH = 2'd2;
  localparam logic [1:0] REG_NONE  = 2'd3;

  localparam logic [7:0] TIMEOUT_DEF = 8'd255;

  // Region 3 is unmapped, so it selects no slave at all.
  function automatic logic [3:0] region_cs(input logic [1:0] region);
    logic [3:0] cs;
    cs = 4'b0000;
    if (region != REG_NONE) cs = 4'b0001 << region;
    return cs;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational 2-way round-robin choice: on a tie the master not served last wins.
// pick_o is only meaningful while vld_o is high.
module bus_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       vld_o,
  output logic       pick_o
);

  always_comb begin
    vld_o  = |req_i;
    pick_o = req_i[1] & (~req_i[0] | ~last_i);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, single-transfer bus arbiter: IDLE arbitrates, ACCESS drives the
// selected slave until it stops being busy (or times out), DONE pulses completion.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m0_wdata,
  input  logic [15:0] m1_wdata,
  input  logic        m0_write,
  input  logic        m1_write,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [15:0] m_rdata,
  output logic        m_err,
  output logic [15:0] s_addr,
  output logic [15:0] s_wdata,
  output logic        s_write,
  output logic [3:0]  s_cs,
  input  logic [15:0] s_rdata0,
  input  logic [15:0] s_rdata1,
  input  logic [15:0] s_rdata2,
  input  logic [2:0]  s_busy
);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        pick_vld, pick;
  logic [1:0]  region;
  logic        busy_sel;
  logic [15:0] rdata_sel;
  logic [7:0]  cnt_inc;

  bus_rr_pick u_pick (
    .req_i  ({m1_req, m0_req}),
    .last_i (last_q),
    .vld_o  (pick_vld),
    .pick_o (pick)
  );

  assign region  = addr_q[15:14];
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    busy_sel  = 1'b0;
    rdata_sel = 16'h0000;
    case (region)
      REG_IO:    begin busy_sel = s_busy[0]; rdata_sel = s_rdata0; end
      REG_RAM:   begin busy_sel = s_busy[1]; rdata_sel = s_rdata1; end
      REG_FLASH: begin busy_sel = s_busy[2]; rdata_sel = s_rdata2; end
      default:   begin busy_sel = 1'b0;      rdata_sel = 16'h0000; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          addr_d  = pick ? m1_addr  : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          write_d = pick ? m1_write : m0_write;
          cnt_d   = 8'd0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (region == REG_NONE) begin
          rdata_d = 16'h0000;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!busy_sel) begin
          rdata_d = write_q ? 16'h0000 : rdata_sel;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_inc == TIMEOUT) begin
          // This busy cycle is the TIMEOUT-th one: give up on the slave.
          rdata_d = 16'h0000;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      write_q <= 1'b0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    m0_done = 1'b0;
    m1_done = 1'b0;
    m_err   = 1'b0;
    s_addr  = 16'h0000;
    s_wdata = 16'h0000;
    s_write = 1'b0;
    s_cs    = 4'b0000;
    m_rdata = rdata_q;
    case (state_q)
      ST_ACCESS: begin
        m0_gnt  = ~owner_q;
        m1_gnt  = owner_q;
        s_addr  = addr_q;
        s_wdata = wdata_q;
        s_write = write_q;
        s_cs    = region_cs(region);
      end
      ST_DONE: begin
        m0_gnt  = ~owner_q;
        m1_gnt  = owner_q;
        m0_done = ~owner_q;
        m1_done = owner_q;
        m_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised and directed bench for bus_arbiter; two instances (default timeout
// and timeout 4) are checked against a transaction-level model of the arbiter.
module tb_bus_arbiter;

  logic clk;
  logic rst_n;

  logic        m0_req[2], m1_req[2], m0_write[2], m1_write[2];
  logic [15:0] m0_addr[2], m1_addr[2], m0_wdata[2], m1_wdata[2];
  logic [15:0] s_rdata0[2], s_rdata1[2], s_rdata2[2];
  logic [2:0]  s_busy[2];

  logic        m0_gnt[2], m1_gnt[2], m0_done[2], m1_done[2], m_err[2], s_write[2];
  logic [15:0] m_rdata[2], s_addr[2], s_wdata[2];
  logic [3:0]  s_cs[2];

  int checks = 0;
  int errors = 0;
  int last_srv[2];
  int tmo[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_arbiter #(.TIMEOUT((g == 0) ? 8'd255 : 8'd4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m0_req   (m0_req[g]),
      .m1_req   (m1_req[g]),
      .m0_addr  (m0_addr[g]),
      .m1_addr  (m1_addr[g]),
      .m0_wdata (m0_wdata[g]),
      .m1_wdata (m1_wdata[g]),
      .m0_write (m0_write[g]),
      .m1_write (m1_write[g]),
      .m0_gnt   (m0_gnt[g]),
      .m1_gnt   (m1_gnt[g]),
      .m0_done  (m0_done[g]),
      .m1_done  (m1_done[g]),
      .m_rdata  (m_rdata[g]),
      .m_err    (m_err[g]),
      .s_addr   (s_addr[g]),
      .s_wdata  (s_wdata[g]),
      .s_write  (s_write[g]),
      .s_cs     (s_cs[g]),
      .s_rdata0 (s_rdata0[g]),
      .s_rdata1 (s_rdata1[g]),
      .s_rdata2 (s_rdata2[g]),
      .s_busy   (s_busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int d);
    m0_req[d] = 1'b0;     m1_req[d] = 1'b0;
    m0_write[d] = 1'b0;   m1_write[d] = 1'b0;
    m0_addr[d] = 16'h0;   m1_addr[d] = 16'h0;
    m0_wdata[d] = 16'h0;  m1_wdata[d] = 16'h0;
    s_rdata0[d] = 16'h0;  s_rdata1[d] = 16'h0;  s_rdata2[d] = 16'h0;
    s_busy[d] = 3'b000;
  endtask

  task automatic chk_quiet(input int d, input string tag);
    chk({tag, "_gnt"},  32'({m1_gnt[d], m0_gnt[d]}), 32'd0);
    chk({tag, "_done"}, 32'({m1_done[d], m0_done[d]}), 32'd0);
    chk({tag, "_cs"},   32'(s_cs[d]), 32'd0);
    chk({tag, "_wr"},   32'(s_write[d]), 32'd0);
  endtask

  // One complete transfer; called one time unit after a rising edge with the DUT idle.
  task automatic xfer(input int d, input logic r0, input logic r1,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] wd0, input logic [15:0] wd1,
                      input logic w0, input logic w1, input int b,
                      input logic drop, input logic [15:0] rdv);
    logic        own;
    logic [15:0] a, wd, exp_rd;
    logic        w, exp_err;
    logic [1:0]  reg_n;
    logic [3:0]  exp_cs;
    int          nacc;
    own   = (r0 && r1) ? (last_srv[d] == 0) : r1;
    a     = own ? a1 : a0;
    wd    = own ? wd1 : wd0;
    w     = own ? w1 : w0;
    reg_n = a[15:14];
    s_rdata0[d] = 16'($urandom);
    s_rdata1[d] = 16'($urandom);
    s_rdata2[d] = 16'($urandom);
    case (reg_n)
      2'd0: s_rdata0[d] = rdv;
      2'd1: s_rdata1[d] = rdv;
      2'd2: s_rdata2[d] = rdv;
      default: ;
    endcase
    exp_cs = (reg_n == 2'd3) ? 4'b0000 : (4'b0001 << reg_n);
    if (reg_n == 2'd3) begin
      nacc = 1; exp_rd = 16'h0; exp_err = 1'b1;
    end else if (b >= tmo[d]) begin
      nacc = tmo[d]; exp_rd = 16'h0; exp_err = 1'b1;
    end else begin
      nacc = b + 1; exp_rd = w ? 16'h0 : rdv; exp_err = 1'b0;
    end
    m0_req[d] = r0;  m1_req[d] = r1;
    m0_addr[d] = a0; m1_addr[d] = a1;
    m0_wdata[d] = wd0; m1_wdata[d] = wd1;
    m0_write[d] = w0;  m1_write[d] = w1;
    @(posedge clk); #1;
    for (int i = 0; i < nacc; i++) begin
      s_busy[d] = 3'($urandom);
      if (reg_n != 2'd3) s_busy[d][reg_n] = (i < b);
      chk("acc_gnt",  32'({m1_gnt[d], m0_gnt[d]}), own ? 32'd2 : 32'd1);
      chk("acc_done", 32'({m1_done[d], m0_done[d]}), 32'd0);
      chk("acc_cs",   32'(s_cs[d]), 32'(exp_cs));
      chk("acc_wr",   32'(s_write[d]), 32'(w));
      chk("acc_addr", 32'(s_addr[d]), 32'(a));
      chk("acc_wdat", 32'(s_wdata[d]), 32'(wd));
      if (i == 0) begin
        if (drop) begin
          if (own) m1_req[d] = 1'b0; else m0_req[d] = 1'b0;
        end
        // A competing request arriving mid-transfer must not steal the bus.
        if ($urandom_range(0, 1) == 1) begin
          if (own) m0_req[d] = 1'b1; else m1_req[d] = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    chk("done_pulse", 32'({m1_done[d], m0_done[d]}), own ? 32'd2 : 32'd1);
    chk("done_gnt",   32'({m1_gnt[d], m0_gnt[d]}), own ? 32'd2 : 32'd1);
    chk("done_cs",    32'(s_cs[d]), 32'd0);
    chk("done_wr",    32'(s_write[d]), 32'd0);
    chk("done_rdata", 32'(m_rdata[d]), 32'(exp_rd));
    chk("done_err",   32'(m_err[d]), 32'(exp_err));
    m0_req[d] = 1'b0; m1_req[d] = 1'b0;
    s_busy[d] = 3'b000;
    @(posedge clk); #1;
    chk_quiet(d, "idle");
    chk("idle_hold_rdata", 32'(m_rdata[d]), 32'(exp_rd));
    last_srv[d] = own ? 1 : 0;
  endtask

  initial begin
    logic [1:0] rq;
    logic [15:0] a0, a1;
    tmo[0] = 255; tmo[1] = 4;
    last_srv[0] = 1; last_srv[1] = 1;
    idle_inputs(0);
    idle_inputs(1);
    rst_n = 1'b0;
    #1;
    chk_quiet(0, "rst0");
    chk_quiet(1, "rst1");
    chk("rst_rdata", 32'(m_rdata[0]), 32'd0);
    chk("rst_saddr", 32'(s_addr[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_quiet(0, "post_rst");

    xfer(0, 1'b1, 1'b0, 16'h4010, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0, 1'b0, 16'hBEEF);
    for (int i = 0; i < 4; i++)
      xfer(0, 1'b1, 1'b1, 16'h0010, 16'h0020, 16'h0, 16'h0, 1'b0, 1'b0, 0, 1'b0, 16'($urandom));
    xfer(0, 1'b0, 1'b1, 16'h0, 16'h8002, 16'h0, 16'h1234, 1'b0, 1'b1, 5, 1'b0, 16'($urandom));
    xfer(1, 1'b1, 1'b0, 16'h8000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1000, 1'b0, 16'h5A5A);
    xfer(0, 1'b1, 1'b0, 16'hC000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0, 1'b0, 16'h7777);
    xfer(1, 1'b0, 1'b1, 16'h0, 16'h0004, 16'h0, 16'h0, 1'b0, 1'b0, 2, 1'b1, 16'h1357);

    for (int n = 0; n < 40; n++) begin
      rq = 2'($urandom_range(1, 3));
      a0 = 16'($urandom);
      a1 = 16'($urandom);
      xfer(int'($urandom_range(0, 1)), rq[0], rq[1], a0, a1, 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), int'($urandom_range(0, 6)), 1'($urandom), 16'($urandom));
    end

    // Reset in the middle of a stalled flash access.
    m0_req[0] = 1'b1; m0_addr[0] = 16'h8000; m0_write[0] = 1'b1;
    @(posedge clk); #1;
    s_busy[0] = 3'b100;
    chk("pre_rst_cs", 32'(s_cs[0]), 32'd4);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_quiet(0, "mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'({m1_done[0], m0_done[0]}), 32'd0);
    end
    idle_inputs(0);
    rst_n = 1'b1;
    last_srv[0] = 1; last_srv[1] = 1;
    @(posedge clk); #1;
    chk_quiet(0, "after_rst");
    xfer(0, 1'b1, 1'b1, 16'h4000, 16'h4002, 16'h0, 16'h0, 1'b0, 1'b0, 0, 1'b0, 16'hCAFE);
    xfer(0, 1'b1, 1'b1, 16'h4000, 16'h4002, 16'h0, 16'h0, 1'b0, 1'b0, 1, 1'b0, 16'hF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
